// File: rtl/seq_gen_ctrl.sv
// -----------------------------------------------------------------------------
// seq_gen_ctrl
//
// Sequence-generation controller that sits between a register file, a data RAM
// and a combinational ALU. A start pulse loads two seed words from RAM into
// registers 0 and 1. The controller then computes r[i+2] = ALU(r[i], r[i+1]).
// Each new term is written to the register file and also to RAM.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle run request (only looked at when idle)
//   abort                 synchronous cancel of a run in progress
//   len                   total terms including both seeds (clamped to 2..2^REG_AW)
//   op                    ALU op code latched for the whole run
//   busy / done           run in progress / one-cycle completion pulse
//   reg_raddr1/2          register file read addresses (combinational read)
//   reg_we/waddr/wdata    register file write port
//   alu_op / alu_result   op presented to the ALU / its combinational result
//   ram_raddr/ram_rdata   RAM read port (data returns one cycle after address)
//   ram_we/waddr/wdata    RAM write port
// -----------------------------------------------------------------------------
module seq_gen_ctrl #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int RAM_AW   = 6,
    parameter int RAM_BASE = 0,
    parameter int OP_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [REG_AW:0]   len,
    input  logic [OP_W-1:0]   op,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] reg_raddr1,
    output logic [REG_AW-1:0] reg_raddr2,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [RAM_AW-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata
);

    localparam int LW = REG_AW + 1;
    localparam logic [LW-1:0]     LEN_MIN   = LW'(2);
    localparam logic [LW-1:0]     LEN_MAX   = LW'(2 ** REG_AW);
    // RAM addresses wrap, so only the low RAM_AW bits of the base matter.
    localparam logic [RAM_AW-1:0] BASE_ADDR = RAM_AW'(RAM_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD0,
        S_LD0W,
        S_LD1W,
        S_CALC,
        S_WB,
        S_DONE
    } state_t;

    state_t            r_state, w_state_next;
    logic [LW-1:0]     r_len, w_len_next;
    logic [OP_W-1:0]   r_op, w_op_next;
    logic [REG_AW-1:0] r_idx, w_idx_next;
    logic [DATA_W-1:0] r_res, w_res_next;
    logic [LW-1:0]     w_len_clamped;
    logic              w_last;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_op    <= '0;
            r_idx   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_len_next;
            r_op    <= w_op_next;
            r_idx   <= w_idx_next;
            r_res   <= w_res_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode (outputs depend only on registered state,
    // apart from the abort gate on the write enables)
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_op_next    = r_op;
        w_idx_next   = r_idx;
        w_res_next   = r_res;

        busy       = 1'b0;
        done       = 1'b0;
        reg_raddr1 = '0;
        reg_raddr2 = '0;
        reg_we     = 1'b0;
        reg_waddr  = '0;
        reg_wdata  = '0;
        alu_op     = '0;
        ram_raddr  = '0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;

        // Fewer than two terms still loads both seeds; more than the register
        // file can hold is cut to its size.
        if (len < LEN_MIN) begin
            w_len_clamped = LEN_MIN;
        end else if (len > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end else begin
            w_len_clamped = len;
        end

        // The term being written in WB is the final one.
        w_last = (({1'b0, r_idx} + LW'(2)) == (r_len - LW'(1)));

        busy   = (r_state == S_LD0)  || (r_state == S_LD0W) ||
                 (r_state == S_LD1W) || (r_state == S_CALC) ||
                 (r_state == S_WB);
        alu_op = busy ? r_op : '0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_len_next   = w_len_clamped;
                    w_op_next    = op;
                    w_state_next = S_LD0;
                end
            end
            S_LD0: begin
                ram_raddr    = BASE_ADDR;
                w_state_next = S_LD0W;
            end
            S_LD0W: begin
                reg_we       = 1'b1;
                reg_waddr    = '0;
                reg_wdata    = ram_rdata;
                ram_raddr    = BASE_ADDR + RAM_AW'(1);
                w_state_next = S_LD1W;
            end
            S_LD1W: begin
                reg_we       = 1'b1;
                reg_waddr    = REG_AW'(1);
                reg_wdata    = ram_rdata;
                w_idx_next   = '0;
                w_state_next = (r_len > LEN_MIN) ? S_CALC : S_DONE;
            end
            S_CALC: begin
                reg_raddr1   = r_idx;
                reg_raddr2   = r_idx + REG_AW'(1);
                w_res_next   = alu_result;
                w_state_next = S_WB;
            end
            S_WB: begin
                reg_we    = 1'b1;
                ram_we    = 1'b1;
                reg_waddr = r_idx + REG_AW'(2);
                ram_waddr = BASE_ADDR + RAM_AW'(r_idx) + RAM_AW'(2);
                reg_wdata = r_res;
                ram_wdata = r_res;
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_idx_next   = r_idx + REG_AW'(1);
                    w_state_next = S_CALC;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Abort drops the run without writing anything in the abort cycle;
        // terms already written are left in place.
        if (busy && abort) begin
            w_state_next = S_IDLE;
            w_idx_next   = r_idx;
            w_res_next   = r_res;
            reg_we       = 1'b0;
            ram_we       = 1'b0;
        end
    end

endmodule

// File: doc/seq_gen_ctrl.md
Name: seq_gen_ctrl

Overview:
- Parametrised sequence-generation controller sitting between the register file, the data RAM and the ALU.
- On a start pulse it loads two seed words from RAM into registers 0 and 1.
- It then iteratively computes r[i+2] = ALU(r[i], r[i+1]) with a programmable ALU op, writing each term to both the register file and RAM.
- It generalises the fixed 32-term Fibonacci controller: runtime length, selectable op, base address, start/busy/done handshake and abort.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register file address width; max terms = 2^REG_AW.
- RAM_AW, 6, RAM address width.
- RAM_BASE, 0, RAM address of seed 0. Term k maps to RAM address (RAM_BASE + k) mod 2^RAM_AW.
- OP_W, 3, ALU op code width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel
- len  in  REG_AW+1  total terms including both seeds
- op  in  OP_W  ALU op for the run
- busy  out  1  high from the cycle after start is accepted until DONE/abort
- done  out  1  one-cycle pulse on completion
- reg_raddr1  out  REG_AW  operand A address (regfile read is combinational)
- reg_raddr2  out  REG_AW  operand B address
- reg_we  out  1  regfile write enable
- reg_waddr  out  REG_AW  regfile write address
- reg_wdata  out  DATA_W  regfile write data
- alu_op  out  OP_W  latched op
- alu_result  in  DATA_W  combinational ALU output
- ram_raddr  out  RAM_AW  RAM read address (1-cycle synchronous read)
- ram_rdata  in  DATA_W  RAM read data
- ram_we  out  1  RAM write enable
- ram_waddr  out  RAM_AW  RAM write address
- ram_wdata  out  DATA_W  RAM write data

Behaviour:
- Reset (rst_n=0, async): state IDLE, all outputs 0, internal len_q/op_q/idx 0.
- States: IDLE, LD0, LD0W, LD1W, CALC, WB, DONE.
- IDLE: on start=1, latch len_q = max(len, 2) clamped to 2^REG_AW, latch op_q = op, go to LD0.
- LD0: ram_raddr = RAM_BASE; go to LD0W.
- LD0W: reg_we=1, reg_waddr=0, reg_wdata=ram_rdata; ram_raddr = RAM_BASE+1; go to LD1W.
- LD1W: reg_we=1, reg_waddr=1, reg_wdata=ram_rdata; idx=0. Go to CALC if len_q>2, else DONE.
- CALC: reg_raddr1=idx, reg_raddr2=idx+1, alu_op=op_q; alu_result registered into res_q at cycle end; go to WB.
- WB: reg_we=1 and ram_we=1; reg_waddr=idx+2; ram_waddr=(RAM_BASE+idx+2) mod 2^RAM_AW; reg_wdata=ram_wdata=res_q. If idx+2 == len_q-1 go to DONE, else idx++ and go to CALC.
- DONE: done=1 for one cycle, busy=0; return to IDLE.
- Output decode and timing:
  - Outputs are decoded from registered state/idx.
  - alu_op holds op_q whenever busy.
  - Enables are 0 outside the states listed.
- Latency: start sampled at cycle 0, done asserted at cycle 4 + 2*(len_q-2).
- Arithmetic: all wrap modulo 2^DATA_W; no overflow flag. RAM addresses wrap modulo 2^RAM_AW.
- Handshake and boundary cases:
  - start while busy is ignored.
  - start and abort together in IDLE: abort wins, stays IDLE.
  - abort while busy: next state IDLE, no done pulse, enables forced 0 in the abort cycle. Writes already committed remain.
  - Mid-run async reset returns to IDLE immediately with all outputs 0.
  - len=0 or 1 is treated as 2: seeds are loaded, no computed terms.

Test Plan:
- RAM[0]=1, RAM[1]=1, len=8, op=ADD -> regs 2..7 = 2,3,5,8,13,21; RAM[2..7] match; done at cycle 16; busy high cycles 1-15.
- Seeds 0xFFFFFFFF and 0x00000001, len=3, ADD -> r2 = 0x00000000 (wrap); done at cycle 6.
- len=0 -> exactly two reg writes (addr 0,1), zero ram_we pulses, done at cycle 4.
- RAM_BASE=62, len=5 -> reads at 62, 63; writes at RAM 0, 1, 2.
- start asserted again while busy -> ignored. abort asserted in the 3rd WB -> no done, no further writes, IDLE next cycle.
- rst_n dropped during CALC -> all outputs 0 asynchronously. A fresh start after release runs a full sequence correctly.
